// File: rtl/gfx_div_arbiter.sv
// ============================================================================
// Module   : gfx_div_arbiter
// Purpose  : Round-robin sharing of one pipelined fixed-point divider between
//            REQS requesters, with a lockstep tag pipe for result routing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gfx_div_arbiter #(
   parameter int REQS   = 2,
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REQS-1:0]       in_valid,
   output logic [REQS-1:0]       in_ready,
   input  logic [REQS*WIDTH-1:0] in_z,
   input  logic [REQS*WIDTH-1:0] in_d,
   output logic [REQS-1:0]       out_valid,
   input  logic [REQS-1:0]       out_ready,
   output logic [WIDTH-1:0]      out_q,
   output logic                  out_dz,
   output logic                  busy,
   output logic [WIDTH-1:0]      div_z,
   output logic [WIDTH-1:0]      div_d,
   output logic                  div_stall,
   input  logic [WIDTH-1:0]      div_q
);

   localparam int c_idw = (REQS > 1) ? $clog2(REQS) : 1;
   localparam logic [WIDTH-1:0] c_qmax = {1'b0, {(WIDTH-1){1'b1}}};

   // Tag pipe: entry STAGES-1 always describes the quotient on div_q.
   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] r_dz;
   logic [c_idw-1:0]  r_id [STAGES];
   logic [c_idw-1:0]  r_ptr;

   logic              w_tail_vld;
   logic [c_idw-1:0]  w_tail_id;
   logic              w_stall;
   logic              w_any;
   logic              w_issue;
   logic [c_idw-1:0]  w_grant;
   logic [WIDTH-1:0]  w_z;
   logic [WIDTH-1:0]  w_d;

   assign w_tail_vld = r_vld[STAGES-1];
   assign w_tail_id  = r_id[STAGES-1];
   assign w_stall    = rst_n && w_tail_vld && !out_ready[w_tail_id];
   assign w_issue    = rst_n && w_any && !w_stall;

   // Scan from the far end so the candidate closest to r_ptr wins.
   always_comb begin
      w_any   = 1'b0;
      w_grant = '0;
      w_z     = '0;
      w_d     = '0;
      for (int k = REQS - 1; k >= 0; k--) begin
         int idx;
         idx = int'(r_ptr) + k;
         if (idx >= REQS) idx = idx - REQS;
         if (in_valid[idx]) begin
            w_any   = 1'b1;
            w_grant = c_idw'(idx);
            w_z     = in_z[idx*WIDTH +: WIDTH];
            w_d     = in_d[idx*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && w_any && !w_stall) in_ready[w_grant] = 1'b1;
   end

   always_comb begin
      out_valid = '0;
      if (rst_n && w_tail_vld) out_valid[w_tail_id] = 1'b1;
   end

   assign div_z     = w_z;
   assign div_d     = w_d;
   assign div_stall = w_stall;
   assign out_dz    = r_dz[STAGES-1];
   assign out_q     = r_dz[STAGES-1] ? c_qmax : div_q;
   assign busy      = |r_vld;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_dz  <= '0;
         r_ptr <= '0;
         for (int s = 0; s < STAGES; s++) r_id[s] <= '0;
      end else begin
         // Frozen together with the divider so tags never slip against data.
         if (!w_stall) begin
            for (int s = STAGES - 1; s > 0; s--) begin
               r_vld[s] <= r_vld[s-1];
               r_dz[s]  <= r_dz[s-1];
               r_id[s]  <= r_id[s-1];
            end
            r_vld[0] <= w_issue;
            r_dz[0]  <= w_issue && (w_d == '0);
            r_id[0]  <= w_grant;
         end
         if (w_issue) begin
            r_ptr <= (w_grant == c_idw'(REQS - 1)) ? '0 : w_grant + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
